// File: rtl/oai32_seq_pkg.sv
// Shared types and constants for the oai32 cell self-test sequencer.
package oai32_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_e;

   localparam int unsigned VEC_W   = 5;
   localparam int unsigned NUM_VEC = 32;
   localparam int unsigned ERR_W   = 6;

   // Bit positions of each cell input within the sweep vector.
   localparam int unsigned IDX_A1 = 0;
   localparam int unsigned IDX_A2 = 1;
   localparam int unsigned IDX_A3 = 2;
   localparam int unsigned IDX_B1 = 3;
   localparam int unsigned IDX_B2 = 4;

endpackage

// File: rtl/oai32_golden_model.sv
// Combinational reference OAI32 function: ZN = ~((A1|A2|A3) & (B1|B2)).
module oai32_golden_model
   import oai32_seq_pkg::*;
(
   input  logic [VEC_W-1:0] VEC,
   output logic             ZN_EXP
);

   assign ZN_EXP = ~((VEC[IDX_A1] | VEC[IDX_A2] | VEC[IDX_A3]) &
                     (VEC[IDX_B1] | VEC[IDX_B2]));

endmodule

// File: rtl/oai32_vector_sequencer.sv
// Exhaustive input sweep of one oai32 cell with settle-time sampling, error count and
// first-failure capture behind a START/BUSY/DONE handshake.
module oai32_vector_sequencer #(
   parameter int unsigned SETTLE_CYC = 2,
   parameter int unsigned VEC_W      = 5
) (
   input  logic             CLK,
   input  logic             RST,
   inout  wire              VDD,
   inout  wire              VSS,
   input  logic             START,
   input  logic             ABORT,
   input  logic             ZN_IN,
   output logic             A1,
   output logic             A2,
   output logic             A3,
   output logic             B1,
   output logic             B2,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [5:0]       ERR_CNT,
   output logic             FAIL_VLD,
   output logic [VEC_W-1:0] FAIL_VEC
);

   import oai32_seq_pkg::*;

   localparam logic [3:0] RELOAD = 4'(SETTLE_CYC - 1);

   state_e           state_q, state_d;
   logic [VEC_W-1:0] vec_q, vec_d;
   logic [VEC_W-1:0] drv_q, drv_d;
   logic [VEC_W-1:0] fail_vec_q, fail_vec_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             fail_vld_q, fail_vld_d;
   logic             zn_exp;
   logic             mismatch;

   // Supplies only pass through to the cell; nothing here depends on them.
   logic unused_supply;
   assign unused_supply = VDD ^ VSS;

   oai32_golden_model u_golden (
      .VEC    (vec_q),
      .ZN_EXP (zn_exp)
   );

   // Case inequality so an undriven or floating ZN is scored as a failure.
   assign mismatch = (ZN_IN !== zn_exp);

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      drv_d      = drv_q;
      fail_vec_d = fail_vec_q;
      cnt_d      = cnt_q;
      err_cnt_d  = err_cnt_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;
      fail_vld_d = fail_vld_q;

      case (state_q)
         IDLE: begin
            if (START) begin
               state_d    = RUN;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               err_cnt_d  = '0;
               fail_vld_d = 1'b0;
               fail_vec_d = '0;
               vec_d      = '0;
               drv_d      = '0;
               cnt_d      = RELOAD;
            end
         end
         RUN: begin
            if (ABORT) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               drv_d   = '0;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (mismatch) begin
                  if (err_cnt_q != ERR_W'(NUM_VEC)) begin
                     err_cnt_d = err_cnt_q + 1'b1;
                  end
                  if (!fail_vld_q) begin
                     fail_vld_d = 1'b1;
                     fail_vec_d = vec_q;
                  end
               end
               if (vec_q != VEC_W'(NUM_VEC - 1)) begin
                  vec_d = vec_q + 1'b1;
                  drv_d = vec_q + 1'b1;
                  cnt_d = RELOAD;
               end else begin
                  // Result is published on the edge that takes the last sample.
                  state_d = FIN;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_cnt_d == '0);
                  drv_d   = '0;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         vec_q      <= '0;
         drv_q      <= '0;
         fail_vec_q <= '0;
         cnt_q      <= '0;
         err_cnt_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         fail_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         drv_q      <= drv_d;
         fail_vec_q <= fail_vec_d;
         cnt_q      <= cnt_d;
         err_cnt_q  <= err_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         fail_vld_q <= fail_vld_d;
      end
   end

   assign A1       = drv_q[IDX_A1];
   assign A2       = drv_q[IDX_A2];
   assign A3       = drv_q[IDX_A3];
   assign B1       = drv_q[IDX_B1];
   assign B2       = drv_q[IDX_B2];
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign PASS     = pass_q;
   assign ERR_CNT  = err_cnt_q;
   assign FAIL_VLD = fail_vld_q;
   assign FAIL_VEC = fail_vec_q;

endmodule

// File: tb/tb_oai32_vector_sequencer.sv
// Bench for oai32_vector_sequencer: two instances (settle 2 and 1) checked every cycle
// against a sweep-level model, with directed scenarios followed by random traffic.
module tb_oai32_vector_sequencer;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic abort;
   logic zn0;
   logic zn1;
   wire  vdd;
   wire  vss;
   assign vdd = 1'b1;
   assign vss = 1'b0;

   logic [4:0] drv0, drv1, fvec0, fvec1;
   logic [5:0] err0, err1;
   logic       busy0, busy1, done0, done1, pass0, pass1, fvld0, fvld1;

   always #5 clk = ~clk;

   oai32_vector_sequencer #(.SETTLE_CYC(2), .VEC_W(5)) u_dut0 (
      .CLK(clk), .RST(rst), .VDD(vdd), .VSS(vss), .START(start), .ABORT(abort),
      .ZN_IN(zn0), .A1(drv0[0]), .A2(drv0[1]), .A3(drv0[2]), .B1(drv0[3]), .B2(drv0[4]),
      .BUSY(busy0), .DONE(done0), .PASS(pass0), .ERR_CNT(err0), .FAIL_VLD(fvld0),
      .FAIL_VEC(fvec0)
   );

   oai32_vector_sequencer #(.SETTLE_CYC(1), .VEC_W(5)) u_dut1 (
      .CLK(clk), .RST(rst), .VDD(vdd), .VSS(vss), .START(start), .ABORT(abort),
      .ZN_IN(zn1), .A1(drv1[0]), .A2(drv1[1]), .A3(drv1[2]), .B1(drv1[3]), .B2(drv1[4]),
      .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_CNT(err1), .FAIL_VLD(fvld1),
      .FAIL_VEC(fvec1)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int mode = 0;  // 0 good cell, 1 stuck-1, 2 stuck-0, 3 random, 4 bad only at vector 31
   int busy_cnt0 = 0;

   // Model state: a sweep is "edges elapsed since START"; outputs follow from that.
   logic m_run[2], m_fin[2], m_busy[2], m_done[2], m_pass[2], m_fvld[2];
   int   m_k[2], m_err[2], m_fvec[2], m_drv[2];

   function automatic int settle(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   function automatic logic gold(input int v);
      logic [4:0] b;
      b = 5'(v);
      return ~((b[0] | b[1] | b[2]) & (b[3] | b[4]));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_run[i] = 0; m_fin[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0;
         m_fvld[i] = 0; m_k[i] = 0; m_err[i] = 0; m_fvec[i] = 0; m_drv[i] = 0;
      end
   endtask

   task automatic step_one(input int i, input logic st, input logic ab, input logic z);
      int s;
      int v;
      s = settle(i);
      if (m_fin[i]) begin
         m_fin[i] = 0;
      end else if (!m_run[i]) begin
         if (st) begin
            m_run[i] = 1; m_k[i] = 0; m_busy[i] = 1; m_done[i] = 0; m_pass[i] = 0;
            m_err[i] = 0; m_fvld[i] = 0; m_fvec[i] = 0; m_drv[i] = 0;
         end
      end else if (ab) begin
         m_run[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_drv[i] = 0;
      end else begin
         m_k[i]++;
         if (m_k[i] % s == 0) begin
            v = m_k[i] / s - 1;
            if (z !== gold(v)) begin
               if (m_err[i] < 32) m_err[i]++;
               if (!m_fvld[i]) begin
                  m_fvld[i] = 1;
                  m_fvec[i] = v;
               end
            end
            if (v == 31) begin
               m_run[i] = 0; m_fin[i] = 1; m_busy[i] = 0; m_done[i] = 1;
               m_pass[i] = (m_err[i] == 0); m_drv[i] = 0;
            end else begin
               m_drv[i] = v + 1;
            end
         end
      end
   endtask

   function automatic logic zn_for(input int i);
      case (mode)
         1: return 1'b1;
         2: return 1'b0;
         3: return 1'($urandom_range(1, 0));
         4: return (m_run[i] && m_drv[i] == 31) ? ~gold(m_drv[i]) : gold(m_drv[i]);
         default: return gold(m_drv[i]);
      endcase
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_dut(input int i, input logic b, input logic d, input logic p,
                            input logic [5:0] e, input logic fv, input logic [4:0] fvec,
                            input logic [4:0] drv);
      chk($sformatf("d%0d_busy", i), int'(b), int'(m_busy[i]));
      chk($sformatf("d%0d_done", i), int'(d), int'(m_done[i]));
      chk($sformatf("d%0d_pass", i), int'(p), int'(m_pass[i]));
      chk($sformatf("d%0d_err_cnt", i), int'(e), m_err[i]);
      chk($sformatf("d%0d_fail_vld", i), int'(fv), int'(m_fvld[i]));
      chk($sformatf("d%0d_fail_vec", i), int'(fvec), m_fvec[i]);
      chk($sformatf("d%0d_drive", i), int'(drv), m_drv[i]);
   endtask

   task automatic check_all();
      check_dut(0, busy0, done0, pass0, err0, fvld0, fvec0, drv0);
      check_dut(1, busy1, done1, pass1, err1, fvld1, fvec1, drv1);
   endtask

   // Called at a negedge: drive inputs, advance model, compare after the next posedge.
   task automatic tick(input logic st, input logic ab);
      start = st;
      abort = ab;
      zn0   = zn_for(0);
      zn1   = zn_for(1);
      step_one(0, st, ab, zn0);
      step_one(1, st, ab, zn1);
      @(posedge clk);
      @(negedge clk);
      if (busy0) busy_cnt0++;
      check_all();
   endtask

   // Mid-cycle asynchronous reset; outputs must clear without waiting for a clock.
   task automatic do_reset();
      #2 rst = 1'b1;
      model_reset();
      #1 check_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; zn0 = 1'b0; zn1 = 1'b0;
      model_reset();
      @(negedge clk);
      check_all();
      rst = 1'b0;
      tick(0, 0);

      // Fault-free sweep
      mode = 0; busy_cnt0 = 0;
      tick(1, 0);
      repeat (63) tick(0, 0);
      chk("good_done_early", int'(done0), 0);
      tick(0, 0);
      chk("good_busy_cycles", busy_cnt0, 64);
      chk("good_done", int'(done0), 1);
      chk("good_pass", int'(pass0), 1);
      chk("good_err", int'(err0), 0);
      repeat (2) tick(0, 0);

      // Stuck-at-1 cell
      mode = 1;
      tick(1, 0);
      repeat (64) tick(0, 0);
      chk("s1_err", int'(err0), 21);
      chk("s1_fvec", int'(fvec0), 9);
      chk("s1_fvld", int'(fvld0), 1);
      chk("s1_pass", int'(pass0), 0);
      chk("s1_err_fast", int'(err1), 21);
      tick(0, 0);

      // Stuck-at-0 cell
      mode = 2;
      tick(1, 0);
      repeat (64) tick(0, 0);
      chk("s0_err", int'(err0), 11);
      chk("s0_fvec", int'(fvec0), 0);
      chk("s0_pass", int'(pass0), 0);
      chk("s0_done", int'(done0), 1);
      tick(0, 0);

      // Abort 10 cycles in, then a clean full sweep
      mode = 0;
      tick(1, 0);
      repeat (9) tick(0, 0);
      tick(0, 1);
      chk("abort_busy", int'(busy0), 0);
      chk("abort_done", int'(done0), 0);
      chk("abort_drive", int'(drv0), 0);
      tick(0, 0);
      tick(1, 0);
      repeat (64) tick(0, 0);
      chk("after_abort_done", int'(done0), 1);
      chk("after_abort_pass", int'(pass0), 1);
      tick(0, 0);

      // START re-pulsed mid-run is ignored
      tick(1, 0);
      repeat (4) tick(0, 0);
      tick(1, 0);
      repeat (58) tick(0, 0);
      chk("restart_done_early", int'(done0), 0);
      tick(0, 0);
      chk("restart_done", int'(done0), 1);
      tick(0, 0);

      // Reset 20 cycles into a sweep
      tick(1, 0);
      repeat (19) tick(0, 0);
      do_reset();
      chk("rst_busy", int'(busy0), 0);
      chk("rst_drive", int'(drv0), 0);
      tick(0, 0);

      // Single bad sample at vector 31 on the settle-1 instance
      mode = 4;
      tick(1, 0);
      repeat (31) tick(0, 0);
      chk("v31_done_early", int'(done1), 0);
      tick(0, 0);
      chk("v31_done", int'(done1), 1);
      chk("v31_err", int'(err1), 1);
      chk("v31_fvec", int'(fvec1), 31);
      chk("v31_fvld", int'(fvld1), 1);
      repeat (40) tick(0, 0);
      chk("v31_err_slow", int'(err0), 1);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(49, 0) == 0) mode = $urandom_range(4, 0);
         if ($urandom_range(999, 0) == 0) begin
            do_reset();
         end else begin
            tick(1'($urandom_range(19, 0) == 0), 1'($urandom_range(149, 0) == 0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
